// File: rtl/alu_cmd_pkg.sv
// Shared constants for the UART command path: command characters, ALU opcodes
// and parser state encoding.
package alu_cmd_pkg;

  localparam logic [7:0] CH_F = 8'h66;  // 'f' latch operand A
  localparam logic [7:0] CH_R = 8'h72;  // 'r' latch operand B
  localparam logic [7:0] CH_O = 8'h6F;  // 'o' latch opcode
  localparam logic [7:0] CH_D = 8'h64;  // 'd' dispatch
  localparam logic [7:0] CH_C = 8'h63;  // 'c' clear

  localparam int OP_ADD = 32;
  localparam int OP_SUB = 34;
  localparam int OP_AND = 36;
  localparam int OP_OR  = 37;
  localparam int OP_XOR = 38;
  localparam int OP_SRA = 3;
  localparam int OP_SRL = 2;
  localparam int OP_NOR = 39;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

endpackage

// File: rtl/rx_cmd_parser_dec_accum.sv
// Decimal digit accumulator: value = value*10 + digit, saturating at 2^DW-1
// with a sticky overflow flag when the value or the digit count is exceeded.
module dec_accum #(
  parameter int DW         = 8,
  parameter int MAX_DIGITS = 3,
  parameter int NW         = $clog2(MAX_DIGITS + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          digit_en,
  input  logic [3:0]    digit,
  output logic [DW-1:0] value,
  output logic [NW-1:0] ndig,
  output logic          ovf
);
  localparam int AW = DW + 4;
  localparam int PW = DW + 8;
  localparam logic [PW-1:0] LIM = {{(PW-DW){1'b0}}, {DW{1'b1}}};

  logic [AW-1:0] acc_q, acc_d;
  logic [NW-1:0] ndig_q, ndig_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] prod;

  always_comb begin
    acc_d  = acc_q;
    ndig_d = ndig_q;
    ovf_d  = ovf_q;
    prod   = PW'(acc_q) * PW'(10) + PW'(digit);
    if (clr) begin
      acc_d  = '0;
      ndig_d = '0;
      ovf_d  = 1'b0;
    end else if (digit_en) begin
      // count saturates one past the limit so it can never wrap back to legal
      if (ndig_q <= NW'(MAX_DIGITS)) ndig_d = ndig_q + NW'(1);
      ovf_d = ovf_q || (prod > LIM) || (ndig_d > NW'(MAX_DIGITS));
      acc_d = ovf_d ? AW'(LIM) : prod[AW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      ndig_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ndig_q <= ndig_d;
      ovf_q  <= ovf_d;
    end
  end

  assign value = acc_q[DW-1:0];
  assign ndig  = ndig_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/rx_cmd_parser.sv
// ASCII command parser: builds decimal operands A/B and an opcode from UART bytes,
// presents the command under a level valid / ack handshake.
module rx_cmd_parser
  import alu_cmd_pkg::*;
#(
  parameter int DW         = 8,
  parameter int MAX_DIGITS = 3,
  parameter int OPW        = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_done_tick,
  input  logic [7:0]     rx_data,
  input  logic           cmd_ack,
  output logic [DW-1:0]  a,
  output logic [DW-1:0]  b,
  output logic [OPW-1:0] op,
  output logic           cmd_valid,
  output logic           cmd_err,
  output logic           cmd_ovr
);
  localparam int NW = $clog2(MAX_DIGITS + 2);

  logic [0:0]     state_q, state_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d, acc_value;
  logic [OPW-1:0] op_q, op_d;
  logic [7:0]     sym_q, sym_d;
  logic           have_a_q, have_a_d, have_b_q, have_b_d, have_op_q, have_op_d;
  logic           valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
  logic           proc, is_digit, acc_clr, digit_en, acc_ovf;
  logic [NW-1:0]  acc_ndig;
  logic [OPW:0]   map;

  function automatic logic [OPW:0] map_sym(input logic [7:0] s);
    case (s)
      8'h2B:   map_sym = {1'b1, OPW'(OP_ADD)};  // '+'
      8'h2D:   map_sym = {1'b1, OPW'(OP_SUB)};  // '-'
      8'h26:   map_sym = {1'b1, OPW'(OP_AND)};  // '&'
      8'h7C:   map_sym = {1'b1, OPW'(OP_OR)};   // '|'
      8'h78:   map_sym = {1'b1, OPW'(OP_XOR)};  // 'x'
      8'h61:   map_sym = {1'b1, OPW'(OP_SRA)};  // 'a'
      8'h6C:   map_sym = {1'b1, OPW'(OP_SRL)};  // 'l'
      8'h6E:   map_sym = {1'b1, OPW'(OP_NOR)};  // 'n'
      default: map_sym = '0;
    endcase
  endfunction

  dec_accum #(.DW(DW), .MAX_DIGITS(MAX_DIGITS), .NW(NW)) u_acc (
    .clk(clk), .reset(reset), .clr(acc_clr), .digit_en(digit_en),
    .digit(rx_data[3:0]), .value(acc_value), .ndig(acc_ndig), .ovf(acc_ovf)
  );

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign map      = map_sym(sym_q);

  always_comb begin
    state_d = state_q;  a_d = a_q;  b_d = b_q;  op_d = op_q;  sym_d = sym_q;
    have_a_d = have_a_q;  have_b_d = have_b_q;  have_op_d = have_op_q;
    valid_d = valid_q;  err_d = 1'b0;  ovr_d = ovr_q;
    acc_clr = 1'b0;  digit_en = 1'b0;  proc = 1'b0;

    // ack is applied first so a same-edge byte sees the cleared have_* flags
    if (state_q == ST_PENDING) begin
      if (cmd_ack) begin
        valid_d = 1'b0;  state_d = ST_COLLECT;
        have_a_d = 1'b0;  have_b_d = 1'b0;  have_op_d = 1'b0;
        proc = rx_done_tick;
      end else if (rx_done_tick) begin
        ovr_d = 1'b1;
      end
    end else begin
      proc = rx_done_tick;
    end

    if (proc) begin
      if (is_digit) begin
        digit_en = 1'b1;
      end else begin
        case (rx_data)
          CH_F: begin
            acc_clr = 1'b1;  sym_d = '0;
            if (!acc_ovf && acc_ndig != '0) begin a_d = acc_value; have_a_d = 1'b1; end
            else err_d = 1'b1;
          end
          CH_R: begin
            acc_clr = 1'b1;  sym_d = '0;
            if (!acc_ovf && acc_ndig != '0) begin b_d = acc_value; have_b_d = 1'b1; end
            else err_d = 1'b1;
          end
          CH_O: begin
            acc_clr = 1'b1;  sym_d = '0;
            if (map[OPW]) begin op_d = map[OPW-1:0]; have_op_d = 1'b1; end
            else err_d = 1'b1;
          end
          CH_D: begin
            if (have_a_d && have_b_d && have_op_d) begin
              valid_d = 1'b1;  state_d = ST_PENDING;
            end else begin
              err_d = 1'b1;
              have_a_d = 1'b0;  have_b_d = 1'b0;  have_op_d = 1'b0;
            end
          end
          CH_C: begin
            acc_clr = 1'b1;  sym_d = '0;  ovr_d = 1'b0;
            have_a_d = 1'b0;  have_b_d = 1'b0;  have_op_d = 1'b0;
          end
          default: sym_d = rx_data;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_COLLECT;  a_q <= '0;  b_q <= '0;  op_q <= '0;  sym_q <= '0;
      have_a_q <= 1'b0;  have_b_q <= 1'b0;  have_op_q <= 1'b0;
      valid_q <= 1'b0;  err_q <= 1'b0;  ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  op_q <= op_d;  sym_q <= sym_d;
      have_a_q <= have_a_d;  have_b_q <= have_b_d;  have_op_q <= have_op_d;
      valid_q <= valid_d;  err_q <= err_d;  ovr_q <= ovr_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign cmd_valid = valid_q;
  assign cmd_err   = err_q;
  assign cmd_ovr   = ovr_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Bench for rx_cmd_parser: directed scenarios plus random byte/ack traffic, all
// checked against a string-level model of the command language.
module tb_rx_cmd_parser;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_ack = 1'b0;
  logic [7:0] a, b;
  logic [5:0] op;
  logic       cmd_valid, cmd_err, cmd_ovr;

  int n_vec = 0;
  int n_mis = 0;

  // model state: pending digits kept as a list, operand value computed only on latch
  int         m_dq[$];
  logic [7:0] m_sym;
  logic       m_ha, m_hb, m_ho;
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  logic       m_valid, m_err, m_ovr;

  rx_cmd_parser #(.DW(8), .MAX_DIGITS(3), .OPW(6)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .cmd_ack(cmd_ack), .a(a), .b(b), .op(op),
    .cmd_valid(cmd_valid), .cmd_err(cmd_err), .cmd_ovr(cmd_ovr)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] got_vec();
    return {cmd_valid, cmd_err, cmd_ovr, a, b, op, 3'b000};
  endfunction
  function automatic logic [29:0] exp_vec();
    return {m_valid, m_err, m_ovr, m_a, m_b, m_op, 3'b000};
  endfunction

  task automatic model_reset();
    m_dq.delete();
    m_sym = 0; m_ha = 0; m_hb = 0; m_ho = 0;
    m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_err = 0; m_ovr = 0;
  endtask

  // operand is legal when it has 1..3 digits and its decimal value fits in 8 bits
  task automatic model_field(output logic ok, output logic [7:0] val);
    int v = 0;
    foreach (m_dq[i]) v = v * 10 + m_dq[i];
    ok  = (m_dq.size() > 0) && (m_dq.size() <= 3) && (v <= 255);
    val = v[7:0];
    m_dq.delete();
    m_sym = 0;
  endtask

  task automatic model_step(input logic tk, input logic [7:0] ch, input logic ak);
    logic       ok;
    logic [7:0] v;
    m_err = 0;
    if (m_valid && ak) begin
      m_valid = 0; m_ha = 0; m_hb = 0; m_ho = 0;
    end else if (m_valid) begin
      if (tk) m_ovr = 1;
      return;
    end
    if (!tk) return;
    if (ch >= "0" && ch <= "9") m_dq.push_back(int'(ch) - 48);
    else if (ch == "f") begin model_field(ok, v); if (ok) begin m_a = v; m_ha = 1; end else m_err = 1; end
    else if (ch == "r") begin model_field(ok, v); if (ok) begin m_b = v; m_hb = 1; end else m_err = 1; end
    else if (ch == "o") begin
      ok = 1;
      case (m_sym)
        "+": m_op = 32;  "-": m_op = 34;  "&": m_op = 36;  "|": m_op = 37;
        "x": m_op = 38;  "a": m_op = 3;   "l": m_op = 2;   "n": m_op = 39;
        default: ok = 0;
      endcase
      if (ok) m_ho = 1; else m_err = 1;
      m_dq.delete(); m_sym = 0;
    end else if (ch == "d") begin
      if (m_ha && m_hb && m_ho) m_valid = 1;
      else begin m_err = 1; m_ha = 0; m_hb = 0; m_ho = 0; end
    end else if (ch == "c") begin
      m_dq.delete(); m_sym = 0; m_ha = 0; m_hb = 0; m_ho = 0; m_ovr = 0;
    end else m_sym = ch;
  endtask

  task automatic apply(input logic tk, input logic [7:0] ch, input logic ak);
    @(negedge clk);
    rx_done_tick = tk; rx_data = ch; cmd_ack = ak;
    model_step(tk, ch, ak);
    @(posedge clk); #1;
    rx_done_tick = 0; cmd_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1;
    model_reset();
    #1;
    n_vec++;
    if (got_vec() !== exp_vec()) begin
      n_mis++; $display("FAIL reset_async got=%h want=%h", got_vec(), exp_vec());
    end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(0, 8'h00, 1);
    n_vec++;
    if (got_vec() !== 30'd0) begin n_mis++; $display("FAIL reset_idle got=%h want=0", got_vec()); end
  endtask

  task automatic test_basic();
    string s = "12f34r+od";
    for (int i = 0; i < s.len(); i++) begin
      apply(1, s[i], 0);
      n_vec++;
      if (got_vec() !== exp_vec()) begin n_mis++; $display("FAIL basic[%0d] got=%h want=%h", i, got_vec(), exp_vec()); end
    end
    n_vec++;
    if ({cmd_valid, a, b, op} !== {1'b1, 8'd12, 8'd34, 6'd32}) begin
      n_mis++; $display("FAIL basic_cmd got=%b/%0d/%0d/%0d want=1/12/34/32", cmd_valid, a, b, op);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 8'h00, i == 2);
      n_vec++;
      if (cmd_valid !== (i != 2)) begin n_mis++; $display("FAIL basic_hold[%0d] got=%b want=%b", i, cmd_valid, i != 2); end
    end
  endtask

  task automatic test_overflow();
    string s = "256f1234f255f";
    for (int i = 0; i < s.len(); i++) begin
      apply(1, s[i], 0);
      n_vec++;
      if (got_vec() !== exp_vec()) begin n_mis++; $display("FAIL ovf[%0d] got=%h want=%h", i, got_vec(), exp_vec()); end
      if (i == 3 || i == 8) begin
        n_vec++;
        if ({cmd_err, a} !== {1'b1, 8'd12}) begin n_mis++; $display("FAIL ovf_err[%0d] got=%b/%0d want=1/12", i, cmd_err, a); end
      end
    end
    n_vec++;
    if ({cmd_err, a} !== {1'b0, 8'd255}) begin n_mis++; $display("FAIL ovf_255 got=%b/%0d want=0/255", cmd_err, a); end
  endtask

  task automatic test_bad_op();
    string s = "5f?od";
    for (int i = 0; i < s.len(); i++) begin
      apply(1, s[i], 0);
      n_vec++;
      if (got_vec() !== exp_vec()) begin n_mis++; $display("FAIL badop[%0d] got=%h want=%h", i, got_vec(), exp_vec()); end
      if (i >= 3) begin
        n_vec++;
        if ({cmd_err, cmd_valid} !== 2'b10) begin n_mis++; $display("FAIL badop_err[%0d] got=%b want=10", i, {cmd_err, cmd_valid}); end
      end
    end
  endtask

  task automatic test_overrun();
    string s = "1f2r-od7";
    for (int i = 0; i < s.len(); i++) begin
      apply(1, s[i], 0);
      n_vec++;
      if (got_vec() !== exp_vec()) begin n_mis++; $display("FAIL ovr[%0d] got=%h want=%h", i, got_vec(), exp_vec()); end
    end
    n_vec++;
    if ({cmd_ovr, cmd_valid, a, b, op} !== {2'b11, 8'd1, 8'd2, 6'd34}) begin
      n_mis++; $display("FAIL ovr_set got=%b%b/%0d/%0d/%0d want=11/1/2/34", cmd_ovr, cmd_valid, a, b, op);
    end
    apply(0, 8'h00, 1);
    apply(1, "c", 0);
    n_vec++;
    if ({cmd_ovr, cmd_valid} !== 2'b00) begin n_mis++; $display("FAIL ovr_clr got=%b want=00", {cmd_ovr, cmd_valid}); end
  endtask

  task automatic test_ack_tick();
    string s = "3f4r&od";
    for (int i = 0; i < s.len(); i++) apply(1, s[i], 0);
    apply(1, "9", 1);
    n_vec++;
    if ({cmd_valid, cmd_ovr, cmd_err} !== 3'b000) begin n_mis++; $display("FAIL acktick got=%b want=000", {cmd_valid, cmd_ovr, cmd_err}); end
    apply(1, "f", 0);
    n_vec++;
    if ({a, cmd_err} !== {8'd9, 1'b0}) begin n_mis++; $display("FAIL acktick_a got=%0d/%b want=9/0", a, cmd_err); end
    n_vec++;
    if (got_vec() !== exp_vec()) begin n_mis++; $display("FAIL acktick_model got=%h want=%h", got_vec(), exp_vec()); end
  endtask

  task automatic test_reset_midfield();
    string s = "2f3rxod";
    apply(1, "4", 0);
    do_reset();
    n_vec++;
    if (got_vec() !== 30'd0) begin n_mis++; $display("FAIL midreset got=%h want=0", got_vec()); end
    for (int i = 0; i < s.len(); i++) apply(1, s[i], 0);
    n_vec++;
    if ({cmd_valid, a, b, op} !== {1'b1, 8'd2, 8'd3, 6'd38}) begin
      n_mis++; $display("FAIL midreset_cmd got=%b/%0d/%0d/%0d want=1/2/3/38", cmd_valid, a, b, op);
    end
    apply(0, 8'h00, 1);
  endtask

  task automatic test_random();
    string alph = "01234567890123456789frfrooddc+-&|xaln?Zd";
    for (int i = 0; i < 600; i++) begin
      logic [7:0] ch;
      logic       tk, ak;
      ch = alph[$urandom_range(alph.len() - 1)];
      tk = ($urandom_range(7) != 0);
      ak = ($urandom_range(3) == 0);
      apply(tk, ch, ak);
      n_vec++;
      if (got_vec() !== exp_vec()) begin
        n_mis++; $display("FAIL rand[%0d] ch=%h tk=%b ak=%b got=%h want=%h", i, ch, tk, ak, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_bad_op();
    test_overrun();
    test_ack_tick();
    test_reset_midfield();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
